ddr3_memory_responder: RTL
==========================

Name: ddr3_memory_responder

Overview:
Synthesizable, clk-domain responder for the DDR3 command/data interface. It stands in for the external DDR3 device on the target side: it decodes commands from ddr3_memory_controller, tracks bank/row state, stores write bursts in a small on-chip array and returns read bursts with CAS latency. Its purpose is on-FPGA loopback and regression when no physical DRAM or Micron model is present. Status outputs feed ILA and bench checkers.

Parameters:
DQ_BITWIDTH, 16, data width (x16 device, two byte lanes)
DM_BITWIDTH, 2, byte-lane count for dm and dqs
ADDRESS_BITWIDTH, 14, address bus width
BANK_ADDRESS_BITWIDTH, 3, bank address width (8 banks)
CAS_LATENCY, 5, read latency in ck cycles, minimum 2
CAS_WRITE_LATENCY, 5, write latency in ck cycles, minimum 1
MEM_ADDR_BITWIDTH, 6, storage depth is 2^MEM_ADDR_BITWIDTH words

Ports:
clk  in  1  responder clock, at least 4x ck frequency
reset  in  1  synchronous, active-high
reset_n  in  1  DDR reset; low clears bank/burst state
ck  in  1  DDR clock sampled in clk domain
ck_en  in  1  CKE
cs_n, ras_n, cas_n, we_n  in  1 each  command bus
bank_address  in  BANK_ADDRESS_BITWIDTH  bank
address  in  ADDRESS_BITWIDTH  row/column/mode value
dm  in  DM_BITWIDTH  write byte mask, 1 = lane not written
dq_in  in  DQ_BITWIDTH  write data from controller
dq_out  out  DQ_BITWIDTH  read data
dq_oe  out  1  dq drive enable
dqs_out, dqs_n_out  out  DM_BITWIDTH each  read strobe, dqs_n_out = ~dqs_out
dqs_oe  out  1  strobe drive enable
open_bank_mask  out  8  bit b = bank b open
refresh_count  out  16  REF commands accepted, saturating
mode_register_0  out  ADDRESS_BITWIDTH  last MR0 value
protocol_error  out  1  sticky error flag
error_code  out  3  code of first error

Behaviour:
- Reset values: dq_out 0, dq_oe 0, dqs_out 0, dqs_n_out all ones, dqs_oe 0, open_bank_mask 0, refresh_count 0, mode_register_0 0, protocol_error 0, error_code 0. The storage array is never cleared.
- reset_n low, sampled on clk: clears bank state and aborts bursts. Drive enables drop on the next clk. Counters, MR0 and error flags are retained.
- Edge detect: ck_q registered each clk. ck_rise = ck & ~ck_q. ck_fall = ~ck & ck_q. Each ck level must span at least 2 clk.
- Decode on ck_rise only when reset_n=1, ck_en=1 and cs_n=0. {ras_n,cas_n,we_n}: 000 MRS, 001 REF, 010 PRE, 011 ACT, 100 WR, 101 RD, 110 ZQ (no-op), 111 NOP.
- MRS: bank_address=0 loads mode_register_0 with address. Other banks are accepted and ignored.
- ACT: if the bank is open, error code 1 and the state is unchanged. Otherwise set the mask bit and store the row, which is informational only.
- PRE: address[10]=1 closes all banks; else closes bank_address. PRE to a closed bank is legal.
- REF: if any bank is open, error code 2 and the count does not increment. Otherwise refresh_count increments, saturating at 0xFFFF.
- RD or WR to a closed bank: error code 3 for RD, 4 for WR; the command is ignored.
- RD or WR while the burst engine is busy, from command until the postamble ends: error code 5; ignored.
- Error reporting: protocol_error sets on the first error. error_code latches that first error and is not overwritten until reset.
- Burst address: word index = low MEM_ADDR_BITWIDTH bits of {bank_address, address[9:3], beat[2:0]}. Row is ignored (aliased). BL8, sequential, address[2:0] ignored.
- Write: counts ck_rise after WR. On the CAS_WRITE_LATENCY-th ck_rise, beat 0 is sampled from dq_in. Beats 1..7 are sampled on the following alternating ck_fall/ck_rise, so beat 7 lands on a ck_fall. Per byte lane, dm=1 leaves the stored byte unchanged.
- Read preamble: on the (CAS_LATENCY-1)-th ck_rise after RD, dqs_oe=1 and dqs_out=0.
- Read data: on the CAS_LATENCY-th ck_rise, dq_oe=1, dq_out=beat 0, dqs_out all ones. Each following ck edge advances one beat and toggles dqs. Beat 7 is driven on a ck_fall with dqs_out=0.
- Read postamble: on the next ck_rise, dq_oe=0 and dq_out=0 while dqs_out stays 0. On the following ck_fall, dqs_oe=0 and the engine goes idle.
- Read and write memory access is single-cycle: registered read port, combinational address.
- States: IDLE -> WR_WAIT -> WR_BURST -> IDLE. IDLE -> RD_WAIT -> RD_PRE -> RD_BURST -> RD_POST -> IDLE.
- ck_en low: new commands are ignored; an active burst continues counting ck edges.
- Reset mid-burst: next clk all outputs take their reset values; a partial write keeps the beats already stored.

Test Plan:
- MRS, BA=0, address=0x0520 -> mode_register_0=0x0520, protocol_error=0.
- ACT bank 2, WR col 0x008, dq_in beats 0x1111..0x8888, dm=0; then RD bank 2 col 0x008 -> beats 0x1111..0x8888 starting on the 5th ck_rise; dq_oe high exactly 4 ck; dqs toggles 8 edges; dqs_oe spans preamble to postamble.
- Rewrite the same burst with beat 2 = 0xABCD and dm=2'b01 on beat 2 only -> readback beat 2 = 0xAB33, other beats match the new data.
- RD bank 5 (closed) -> protocol_error=1, error_code=3, dq_oe never asserts. A subsequent ACT to open bank 2 keeps error_code=3.
- After reset: 3x REF with all banks closed -> refresh_count=3. ACT banks 0 and 7 -> open_bank_mask=0x81. REF -> error_code=2, count stays 3. PRE with A10=1 -> mask 0x00.
- Assert reset during RD_BURST beat 3 -> next clk dq_oe=0, dqs_oe=0, dqs_n_out=2'b11. A new ACT/RD after reset release completes normally.

Source files
------------

// File: rtl/ddr3_memory_responder_if.sv
// rtl/ddr3_memory_responder_if.sv - DDR3 command/data bus between controller (master) and responder (slave).
interface ddr3_memory_responder_if #(
  parameter int DQ_BITWIDTH           = 16,
  parameter int DM_BITWIDTH           = 2,
  parameter int ADDRESS_BITWIDTH      = 14,
  parameter int BANK_ADDRESS_BITWIDTH = 3
);
  logic                             reset_n;
  logic                             ck;
  logic                             ck_en;
  logic                             cs_n;
  logic                             ras_n;
  logic                             cas_n;
  logic                             we_n;
  logic [BANK_ADDRESS_BITWIDTH-1:0] bank_address;
  logic [ADDRESS_BITWIDTH-1:0]      address;
  logic [DM_BITWIDTH-1:0]           dm;
  logic [DQ_BITWIDTH-1:0]           dq_in;
  logic [DQ_BITWIDTH-1:0]           dq_out;
  logic                             dq_oe;
  logic [DM_BITWIDTH-1:0]           dqs_out;
  logic [DM_BITWIDTH-1:0]           dqs_n_out;
  logic                             dqs_oe;

  modport master (
    output reset_n, ck, ck_en, cs_n, ras_n, cas_n, we_n, bank_address, address, dm, dq_in,
    input  dq_out, dq_oe, dqs_out, dqs_n_out, dqs_oe
  );

  modport slave (
    input  reset_n, ck, ck_en, cs_n, ras_n, cas_n, we_n, bank_address, address, dm, dq_in,
    output dq_out, dq_oe, dqs_out, dqs_n_out, dqs_oe
  );
endinterface

// File: rtl/ddr3_memory_responder.sv
// rtl/ddr3_memory_responder.sv - DDR3 device stand-in: command decode, bank tracking, BL8 burst storage.
// Samples ck in the clk domain and serves read bursts from a small word array with CAS latency.
module ddr3_memory_responder #(
  parameter int DQ_BITWIDTH           = 16,
  parameter int DM_BITWIDTH           = 2,
  parameter int ADDRESS_BITWIDTH      = 14,
  parameter int BANK_ADDRESS_BITWIDTH = 3,
  parameter int CAS_LATENCY           = 5,
  parameter int CAS_WRITE_LATENCY     = 5,
  parameter int MEM_ADDR_BITWIDTH     = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  ddr3_memory_responder_if.slave      ddr,
  output logic [7:0]                  open_bank_mask,
  output logic [15:0]                 refresh_count,
  output logic [ADDRESS_BITWIDTH-1:0] mode_register_0,
  output logic                        protocol_error,
  output logic [2:0]                  error_code
);
  localparam int BASE_W = MEM_ADDR_BITWIDTH - 3;
  localparam int LANE_W = DQ_BITWIDTH / DM_BITWIDTH;

  typedef enum logic [2:0] {IDLE, WR_WAIT, WR_BURST, RD_WAIT, RD_PRE, RD_BURST, RD_POST} state_t;

  state_t                      state_q, state_d;
  logic [7:0]                  cnt_q, cnt_d;
  logic [2:0]                  beat_q, beat_d;
  logic [BASE_W-1:0]           base_q, base_d;
  logic [DQ_BITWIDTH-1:0]      dq_out_q, dq_out_d;
  logic                        dq_oe_q, dq_oe_d;
  logic [DM_BITWIDTH-1:0]      dqs_out_q, dqs_out_d;
  logic                        dqs_oe_q, dqs_oe_d;
  logic [7:0]                  open_q, open_d;
  logic [15:0]                 ref_q, ref_d;
  logic [ADDRESS_BITWIDTH-1:0] mr0_q, mr0_d;
  logic                        perr_q, perr_d;
  logic [2:0]                  code_q, code_d;
  logic [2:0]                  err_c;
  logic                        mem_we;
  logic                        ck_q;
  logic [DQ_BITWIDTH-1:0]      mem_q [2**MEM_ADDR_BITWIDTH];

  logic                         ck_rise, ck_fall, cmd_valid;
  logic [MEM_ADDR_BITWIDTH-1:0] word_addr;

  assign ck_rise   = ddr.ck & ~ck_q;
  assign ck_fall   = ~ddr.ck & ck_q;
  assign cmd_valid = ck_rise & ddr.reset_n & ddr.ck_en & ~ddr.cs_n;
  // Rows alias onto the same words, so only bank, column[9:3] and beat form the index.
  assign word_addr = {base_q, beat_q};

  // ck_q follows ck even in reset so no phantom edge appears on reset release.
  always_ff @(posedge clk) begin
    ck_q <= ddr.ck;
  end

  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      for (int l = 0; l < DM_BITWIDTH; l++) begin
        if (!ddr.dm[l]) mem_q[word_addr][l*LANE_W +: LANE_W] <= ddr.dq_in[l*LANE_W +: LANE_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      beat_q    <= '0;
      base_q    <= '0;
      dq_out_q  <= '0;
      dq_oe_q   <= 1'b0;
      dqs_out_q <= '0;
      dqs_oe_q  <= 1'b0;
      open_q    <= '0;
      ref_q     <= '0;
      mr0_q     <= '0;
      perr_q    <= 1'b0;
      code_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      beat_q    <= beat_d;
      base_q    <= base_d;
      dq_out_q  <= dq_out_d;
      dq_oe_q   <= dq_oe_d;
      dqs_out_q <= dqs_out_d;
      dqs_oe_q  <= dqs_oe_d;
      open_q    <= open_d;
      ref_q     <= ref_d;
      mr0_q     <= mr0_d;
      perr_q    <= perr_d;
      code_q    <= code_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    beat_d    = beat_q;
    base_d    = base_q;
    dq_out_d  = dq_out_q;
    dq_oe_d   = dq_oe_q;
    dqs_out_d = dqs_out_q;
    dqs_oe_d  = dqs_oe_q;
    open_d    = open_q;
    ref_d     = ref_q;
    mr0_d     = mr0_q;
    perr_d    = perr_q;
    code_d    = code_q;
    err_c     = 3'd0;
    mem_we    = 1'b0;

    if (!ddr.reset_n) begin
      state_d   = IDLE;
      open_d    = '0;
      dq_out_d  = '0;
      dq_oe_d   = 1'b0;
      dqs_out_d = '0;
      dqs_oe_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        WR_WAIT: if (ck_rise) begin
          if (cnt_q + 8'd1 == 8'(CAS_WRITE_LATENCY)) begin
            mem_we  = 1'b1;
            beat_d  = beat_q + 3'd1;
            state_d = WR_BURST;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        WR_BURST: if (ck_rise || ck_fall) begin
          mem_we = 1'b1;
          beat_d = beat_q + 3'd1;
          if (beat_q == 3'd7) state_d = IDLE;
        end
        RD_WAIT: if (ck_rise) begin
          if (cnt_q + 8'd1 == 8'(CAS_LATENCY - 1)) begin
            dqs_oe_d  = 1'b1;
            dqs_out_d = '0;
            state_d   = RD_PRE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        RD_PRE: if (ck_rise) begin
          dq_oe_d   = 1'b1;
          dq_out_d  = mem_q[word_addr];
          dqs_out_d = '1;
          beat_d    = beat_q + 3'd1;
          state_d   = RD_BURST;
        end
        RD_BURST: if (ck_rise || ck_fall) begin
          dq_out_d  = mem_q[word_addr];
          dqs_out_d = ~dqs_out_q;
          beat_d    = beat_q + 3'd1;
          if (beat_q == 3'd7) state_d = RD_POST;
        end
        RD_POST: begin
          if (ck_rise) begin
            dq_oe_d  = 1'b0;
            dq_out_d = '0;
          end else if (ck_fall) begin
            dqs_oe_d = 1'b0;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase

      if (cmd_valid) begin
        case ({ddr.ras_n, ddr.cas_n, ddr.we_n})
          3'b000: if (ddr.bank_address == '0) mr0_d = ddr.address;
          3'b001: begin
            if (open_q != 8'd0) err_c = 3'd2;
            else if (ref_q != 16'hFFFF) ref_d = ref_q + 16'd1;
          end
          3'b010: begin
            if (ddr.address[10]) open_d = '0;
            else open_d[ddr.bank_address] = 1'b0;
          end
          3'b011: begin
            if (open_q[ddr.bank_address]) err_c = 3'd1;
            else open_d[ddr.bank_address] = 1'b1;
          end
          3'b100, 3'b101: begin
            if (!open_q[ddr.bank_address]) begin
              err_c = ddr.we_n ? 3'd3 : 3'd4;
            end else if (state_q != IDLE) begin
              err_c = 3'd5;
            end else begin
              state_d = ddr.we_n ? RD_WAIT : WR_WAIT;
              cnt_d   = '0;
              beat_d  = '0;
              base_d  = BASE_W'({ddr.bank_address, ddr.address[9:3]});
            end
          end
          default: ;
        endcase
      end
    end

    if (err_c != 3'd0 && !perr_q) begin
      perr_d = 1'b1;
      code_d = err_c;
    end
  end

  assign ddr.dq_out       = dq_out_q;
  assign ddr.dq_oe        = dq_oe_q;
  assign ddr.dqs_out      = dqs_out_q;
  assign ddr.dqs_n_out    = ~dqs_out_q;
  assign ddr.dqs_oe       = dqs_oe_q;
  assign open_bank_mask   = open_q;
  assign refresh_count    = ref_q;
  assign mode_register_0  = mr0_q;
  assign protocol_error   = perr_q;
  assign error_code       = code_q;
endmodule
